// File: rtl/viterbi_pipe.sv
// Rate-1/2 K=3 convolutional encoder looped through an internal channel into a 4-state
// hard-decision register-exchange Viterbi decoder. Optional channel error injection: PIPE_ERR_INJECT_EN.
module viterbi_pipe #(
  parameter int TB_DEPTH   = 15,
  parameter int PM_W       = 5,
  parameter int PM_INIT    = 4,
  parameter int ERR_PERIOD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int NS = 4;
  localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

  typedef logic [PM_W-1:0]     pm_t;
  typedef logic [PM_W:0]       cand_t;
  typedef logic [TB_DEPTH-1:0] surv_t;

  logic [1:0] enc_q, enc_d;
  logic [1:0] enc_sym;
  logic [1:0] sym_q, sym_d;
  pm_t        pm_q   [NS];
  pm_t        pm_d   [NS];
  surv_t      surv_q [NS];
  surv_t      surv_d [NS];
  logic       out_q, out_d;

  cand_t      cand_a [NS];
  cand_t      cand_b [NS];
  cand_t      cand   [NS];
  cand_t      norm   [NS];
  logic       pick_b [NS];
  cand_t      cand_min;
  logic [1:0] best;

  // Hamming distance between the received pair and the pair emitted when input u leaves state p.
  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic u,
                                               input logic [1:0] p);
    logic [1:0] exp_sym;
    logic [1:0] diff;
    exp_sym = {u ^ p[1] ^ p[0], u ^ p[0]};
    diff    = rx ^ exp_sym;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // ---------------- encoder ----------------
  always_comb begin
    enc_d   = {in, enc_q[1]};
    enc_sym = {in ^ enc_q[1] ^ enc_q[0], in ^ enc_q[0]};
  end

  // ---------------- channel ----------------
`ifdef PIPE_ERR_INJECT_EN
  localparam int CNT_W = (ERR_PERIOD > 2) ? $clog2(ERR_PERIOD) : 1;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             inject;

  always_comb begin
    inject    = (err_cnt_q == CNT_W'(ERR_PERIOD - 1));
    err_cnt_d = inject ? '0 : err_cnt_q + CNT_W'(1);
    sym_d     = {enc_sym[1] ^ inject, enc_sym[0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end
`else
  always_comb sym_d = enc_sym;
`endif

  // ---------------- add-compare-select ----------------
  // Predecessors of T are {T[0],0} and {T[0],1}; the bit that produced T is T[1].
  always_comb begin
    logic [1:0] pa;
    logic [1:0] pb;
    logic       u;
    // NOTE: every comb output gets a default before any conditional path so no latch can be inferred.
    pa       = '0;
    pb       = '0;
    u        = 1'b0;
    cand_min = '1;
    for (int t = 0; t < NS; t++) begin
      pa        = {t[0], 1'b0};
      pb        = {t[0], 1'b1};
      u         = t[1];
      cand_a[t] = {1'b0, pm_q[pa]} + cand_t'(branch_metric(sym_q, u, pa));
      cand_b[t] = {1'b0, pm_q[pb]} + cand_t'(branch_metric(sym_q, u, pb));
      pick_b[t] = (cand_b[t] < cand_a[t]);
      cand[t]   = pick_b[t] ? cand_b[t] : cand_a[t];
      surv_d[t] = pick_b[t] ? {surv_q[pb][TB_DEPTH-2:0], u}
                            : {surv_q[pa][TB_DEPTH-2:0], u};
      if (cand[t] < cand_min) cand_min = cand[t];
    end
    for (int t = 0; t < NS; t++) begin
      norm[t] = cand[t] - cand_min;
      pm_d[t] = (norm[t] > PM_MAX) ? PM_MAX[PM_W-1:0] : norm[t][PM_W-1:0];
    end
  end

  // ---------------- decision ----------------
  // Best state is judged on the registered metrics, so the output lags the ACS by one edge.
  always_comb begin
    best = 2'd0;
    for (int s = 1; s < NS; s++) begin
      if (pm_q[s] < pm_q[best]) best = 2'(s);
    end
    out_d = surv_q[best][TB_DEPTH-1];
  end

  // ---------------- state registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_q <= '0;
      sym_q <= '0;
      out_q <= 1'b0;
      // NOTE: survivors are flops, not RAM, and must start at zero so early outputs are defined.
      for (int s = 0; s < NS; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : pm_t'(PM_INIT);
        surv_q[s] <= '0;
      end
    end else begin
      enc_q <= enc_d;
      sym_q <= sym_d;
      out_q <= out_d;
      for (int s = 0; s < NS; s++) begin
        pm_q[s]   <= pm_d[s];
        surv_q[s] <= surv_d[s];
      end
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_viterbi_pipe.sv
// Self-checking bench for viterbi_pipe: the reference model is "out equals in delayed by
// TB_DEPTH+1 edges since the last reset release, zero before that".
module tb_viterbi_pipe;

  localparam int TB_DEPTH = 15;
  localparam int LAT      = TB_DEPTH + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic in_b  = 1'b0;
  logic out_b;

  int errors = 0;
  int checks = 0;
  bit hist[$];

  viterbi_pipe #(
    .TB_DEPTH  (TB_DEPTH),
    .PM_W      (5),
    .PM_INIT   (4),
    .ERR_PERIOD(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in_b),
    .out  (out_b)
  );

  always #5 clk = ~clk;

  function automatic logic model_out();
    if (hist.size() > LAT) return hist[hist.size() - 1 - LAT];
    return 1'b0;
  endfunction

  // Present one bit, let the DUT sample it, and return at the following falling edge.
  task automatic drive_bit(input logic b);
    in_b = b;
    @(posedge clk);
    hist.push_back(b);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    in_b  = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    hist.delete();
  endtask

  task automatic test_reset();
    logic exp;
    reset = 1'b1;
    in_b  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_b !== 1'b0) begin
        $display("FAIL reset_hold[%0d] out=%b expected=0", i, out_b);
        errors++;
      end
    end
    reset = 1'b0;
    hist.delete();
    for (int i = 0; i < 20; i++) begin
      drive_bit(1'b0);
      exp = model_out();
      checks++;
      if (out_b !== exp) begin
        $display("FAIL zero_stream[%0d] out=%b expected=%b", i, out_b, exp);
        errors++;
      end
    end
  endtask

  task automatic test_pattern();
    logic       pat [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       b;
    logic       exp;
    do_reset(2);
    for (int i = 0; i < 90; i++) begin
      b = (i < 8) ? pat[i] : 1'($urandom);
      drive_bit(b);
      exp = model_out();
      checks++;
      if (out_b !== exp) begin
        $display("FAIL pattern[%0d] out=%b expected=%b", i, out_b, exp);
        errors++;
      end
    end
  endtask

  task automatic test_all_ones();
    logic exp;
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      drive_bit(1'b1);
      exp = (i >= LAT) ? 1'b1 : 1'b0;
      checks++;
      if (out_b !== exp) begin
        $display("FAIL all_ones[%0d] out=%b expected=%b", i, out_b, exp);
        errors++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic b;
    logic exp;
    for (int i = 0; i < 30; i++) drive_bit(1'b1);
    checks++;
    if (out_b !== 1'b1) begin
      $display("FAIL pre_pulse out=%b expected=1", out_b);
      errors++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_b !== 1'b0) begin
      $display("FAIL pulse_clear out=%b expected=0", out_b);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    for (int i = 0; i < 50; i++) begin
      b = (i < LAT) ? 1'b0 : 1'($urandom);
      drive_bit(b);
      exp = model_out();
      checks++;
      if (out_b !== exp) begin
        $display("FAIL post_pulse[%0d] out=%b expected=%b", i, out_b, exp);
        errors++;
      end
    end
  endtask

  task automatic test_async_between_edges();
    logic exp;
    for (int i = 0; i < LAT + 4; i++) drive_bit(1'b1);
    checks++;
    if (out_b !== 1'b1) begin
      $display("FAIL pre_async out=%b expected=1", out_b);
      errors++;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_b !== 1'b0) begin
      $display("FAIL async_clear out=%b expected=0", out_b);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    for (int i = 0; i < 30; i++) begin
      drive_bit(1'($urandom));
      exp = model_out();
      checks++;
      if (out_b !== exp) begin
        $display("FAIL post_async[%0d] out=%b expected=%b", i, out_b, exp);
        errors++;
      end
    end
  endtask

`ifdef PIPE_ERR_INJECT_EN
  task automatic test_err_inject();
    logic exp;
    do_reset(2);
    for (int i = 0; i < 200 + LAT; i++) begin
      drive_bit(1'($urandom));
      exp = model_out();
      checks++;
      if (out_b !== exp) begin
        $display("FAIL err_inject[%0d] out=%b expected=%b", i, out_b, exp);
        errors++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pattern();
    test_all_ones();
    test_mid_reset();
    test_async_between_edges();
`ifdef PIPE_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
